connect4_drop_ctrl: RTL and testbench

CONNECT4_DROP_CTRL -- requirements
Module: connect4_drop_ctrl

---
 rtl/connect4_drop_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_connect4_drop_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_drop_ctrl.sv
// Connect-4 drop controller: accepts a column, lets the piece fall to the lowest
// empty row, scores the four line directions through the new piece, tracks the winner.
//
// state  | meaning
// IDLE   | waiting for a drop request, move_ready high
// SCAN   | walking up the latched column from row 5 looking for an empty cell
// PLACE  | writing the mover's colour into the found cell
// CHECK  | four cycles, one line direction per cycle, through the placed cell
// RESULT | move_done pulse; declare win/draw or hand the turn over
// OVER   | game finished, board frozen until new_game or rst
module connect4_drop_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_game,
    input  logic                   move_valid,
    input  logic [2:0]             move_col,
    output logic                   move_ready,
    output logic [5:0][6:0][1:0]   board,
    output logic [1:0]             cur_player,
    output logic [1:0]             winner,
    output logic                   game_over,
    output logic                   move_done,
    output logic                   move_reject
);

    typedef enum logic [2:0] {IDLE, SCAN, PLACE, CHECK, RESULT, OVER} state_t;

    state_t                 state_q, state_d;
    logic [5:0][6:0][1:0]   board_q, board_d;
    logic [1:0]             player_q, player_d;
    logic [1:0]             winner_q, winner_d;
    logic [2:0]             col_q, col_d;
    logic [2:0]             row_q, row_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [1:0]             dir_q, dir_d;
    logic                   win_q, win_d;
    logic [2:0]             run_len;

    // Length of the same-colour line through (row_q, col_q) in direction dir_q,
    // counting at most three cells on each side and stopping at the board edge.
    always_comb begin
        int  dr;
        int  dc;
        int  r;
        int  c;
        logic go;
        dr = 0;
        dc = 1;
        r  = 0;
        c  = 0;
        go = 1'b0;
        case (dir_q)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        run_len = 3'd1;
        for (int s = 0; s < 2; s++) begin
            go = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                r = int'(row_q) + ((s == 0) ? k * dr : -k * dr);
                c = int'(col_q) + ((s == 0) ? k * dc : -k * dc);
                if (go && r >= 0 && r <= 5 && c >= 0 && c <= 6) begin
                    if (board_q[r[2:0]][c[2:0]] == player_q)
                        run_len = run_len + 3'd1;
                    else
                        go = 1'b0;
                end else begin
                    go = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        player_d    = player_q;
        winner_d    = winner_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        win_d       = win_q;
        move_done   = 1'b0;
        move_reject = 1'b0;
        case (state_q)
            IDLE: begin
                if (move_valid) begin
                    col_d   = move_col;
                    row_d   = 3'd5;
                    win_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (col_q > 3'd6) begin
                    move_reject = 1'b1;
                    state_d     = IDLE;
                end else if (board_q[row_q][col_q] == 2'b00) begin
                    state_d = PLACE;
                end else if (row_q != 3'd0) begin
                    row_d = row_q - 3'd1;
                end else begin
                    move_reject = 1'b1;
                    state_d     = IDLE;
                end
            end
            PLACE: begin
                board_d[row_q][col_q] = player_q;
                cnt_d   = cnt_q + 6'd1;
                dir_d   = 2'd0;
                state_d = CHECK;
            end
            CHECK: begin
                if (run_len >= 3'd4)
                    win_d = 1'b1;
                dir_d = dir_q + 2'd1;
                if (dir_q == 2'd3)
                    state_d = RESULT;
            end
            RESULT: begin
                move_done = 1'b1;
                if (win_q) begin
                    winner_d = player_q;
                    state_d  = OVER;
                end else if (cnt_q == 6'd42) begin
                    winner_d = 2'b11;
                    state_d  = OVER;
                end else begin
                    player_d = (player_q == 2'b01) ? 2'b10 : 2'b01;
                    state_d  = IDLE;
                end
            end
            OVER: begin
            end
            default: state_d = IDLE;
        endcase
        // A clear discards whatever move is in flight, including its pulse.
        if (new_game || rst) begin
            board_d     = '0;
            player_d    = 2'b01;
            winner_d    = 2'b00;
            cnt_d       = '0;
            win_d       = 1'b0;
            state_d     = IDLE;
            move_done   = 1'b0;
            move_reject = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            board_q  <= '0;
            player_q <= 2'b01;
            winner_q <= 2'b00;
            col_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= '0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            player_q <= player_d;
            winner_q <= winner_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
        end
    end

    assign move_ready = (state_q == IDLE);
    assign game_over  = (state_q == OVER);
    assign board      = board_q;
    assign cur_player = player_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_connect4_drop_ctrl.sv
// Bench for connect4_drop_ctrl: table of directed moves, hand-written corner
// sequences, and random games scored against a gravity/line-search board model.
module tb_connect4_drop_ctrl;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 new_game;
    logic                 move_valid;
    logic [2:0]           move_col;
    logic                 move_ready;
    logic [5:0][6:0][1:0] board;
    logic [1:0]           cur_player;
    logic [1:0]           winner;
    logic                 game_over;
    logic                 move_done;
    logic                 move_reject;

    connect4_drop_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_col    (move_col),
        .move_ready  (move_ready),
        .board       (board),
        .cur_player  (cur_player),
        .winner      (winner),
        .game_over   (game_over),
        .move_done   (move_done),
        .move_reject (move_reject)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain board array, pieces stack from the bottom.
    logic [1:0] mb [6][7];
    int         m_cnt;
    logic [1:0] m_cur;
    logic [1:0] m_win;
    bit         m_over;

    typedef struct {
        bit         ng;
        int         col;
        bit         rej;
        int         lat;
        logic [1:0] cur;
        logic [1:0] win;
        bit         over;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit ng, int col, bit rej, int lat,
                                logic [1:0] cur, logic [1:0] win, bit over);
        vec_t v;
        v.ng = ng; v.col = col; v.rej = rej; v.lat = lat;
        v.cur = cur; v.win = win; v.over = over;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                mb[r][c] = 2'b00;
        m_cnt  = 0;
        m_cur  = 2'b01;
        m_win  = 2'b00;
        m_over = 1'b0;
    endtask

    function automatic logic [83:0] m_pack();
        logic [5:0][6:0][1:0] p;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                p[r][c] = mb[r][c];
        return p;
    endfunction

    // Any four-in-a-row of colour p anywhere on the board.
    function automatic bit m_four(logic [1:0] p);
        int dr [4];
        int dc [4];
        int rr;
        int cc;
        bit all;
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                for (int d = 0; d < 4; d++) begin
                    all = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        rr = r + i * dr[d];
                        cc = c + i * dc[d];
                        if (rr < 0 || rr > 5 || cc < 0 || cc > 6)
                            all = 1'b0;
                        else if (mb[rr][cc] != p)
                            all = 1'b0;
                    end
                    if (all)
                        return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic m_move(input int col, output bit rej, output int lat);
        int k;
        k = 0;
        if (col > 6) begin
            rej = 1'b1;
            lat = 1;
            return;
        end
        for (int r = 0; r < 6; r++)
            if (mb[r][col] != 2'b00)
                k++;
        if (k == 6) begin
            rej = 1'b1;
            lat = 6;
            return;
        end
        rej = 1'b0;
        lat = k + 7;
        mb[5 - k][col] = m_cur;
        m_cnt++;
        if (m_four(m_cur)) begin
            m_win  = m_cur;
            m_over = 1'b1;
        end else if (m_cnt == 42) begin
            m_win  = 2'b11;
            m_over = 1'b1;
        end else begin
            m_cur = (m_cur == 2'b01) ? 2'b10 : 2'b01;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " board"},      board,      m_pack());
        chk({tag, " cur_player"}, cur_player, m_cur);
        chk({tag, " winner"},     winner,     m_win);
        chk({tag, " game_over"},  game_over,  m_over);
        chk({tag, " move_ready"}, move_ready, !m_over);
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        m_reset();
    endtask

    task automatic do_move(input int col, output bit got_rej, output int got_lat);
        bit e_rej;
        int e_lat;
        m_move(col, e_rej, e_lat);
        move_valid = 1'b1;
        move_col   = col[2:0];
        step();
        move_valid = 1'b0;
        move_col   = 3'($urandom_range(0, 7));
        got_lat = 1;
        while (!move_done && !move_reject && got_lat < 40) begin
            step();
            got_lat++;
        end
        got_rej = move_reject;
        chk($sformatf("col%0d pulse done/reject", col), {move_done, move_reject},
            e_rej ? 2'b01 : 2'b10);
        chk($sformatf("col%0d latency", col), got_lat, e_lat);
        step();
        chk("pulse width", {move_done, move_reject}, 2'b00);
        check_state($sformatf("after col%0d", col));
    endtask

    task automatic watch_quiet(input int cycles, output bit saw);
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (move_done || move_reject)
                saw = 1'b1;
            step();
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   r;
        int   l;
        bit   saw;
        int   q[$];
        int   col;
        int   moves;

        rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_col = 3'd0;
        m_reset();
        repeat (3) step();
        rst = 1'b0;
        chk("reset board", board, 84'd0);
        chk("reset cur_player", cur_player, 2'b01);
        chk("reset winner", winner, 2'b00);
        chk("reset game_over", game_over, 1'b0);
        chk("reset pulses", {move_done, move_reject}, 2'b00);
        step();
        chk("ready after reset", move_ready, 1'b1);

        // Single drop into col 3 on an empty board.
        do_move(3, r, l);
        chk("col3 latency", l, 7);
        chk("col3 board[5][3]", board[5][3], 2'b01);
        chk("col3 cur_player", cur_player, 2'b10);

        // Directed table: illegal column, full column, diagonal win, row win.
        vt.push_back(mk(1, 7, 1, 1, 2'b01, 2'b00, 0));
        vt.push_back(mk(0, 3, 0, 7, 2'b10, 2'b00, 0));
        vt.push_back(mk(1, 0, 0, 7,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 0, 0, 8,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 0, 0, 9,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 0, 0, 10, 2'b01, 2'b00, 0));
        vt.push_back(mk(0, 0, 0, 11, 2'b10, 2'b00, 0));
        vt.push_back(mk(0, 0, 0, 12, 2'b01, 2'b00, 0));
        vt.push_back(mk(0, 0, 1, 6,  2'b01, 2'b00, 0));
        vt.push_back(mk(1, 1, 0, 7,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 0, 0, 7,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 2, 0, 7,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 1, 0, 8,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 3, 0, 7,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 6, 0, 7,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 2, 0, 8,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 2, 0, 9,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 3, 0, 8,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 6, 0, 8,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 3, 0, 9,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 3, 0, 10, 2'b10, 2'b10, 1));
        vt.push_back(mk(1, 0, 0, 7,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 0, 0, 8,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 1, 0, 7,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 1, 0, 8,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 2, 0, 7,  2'b10, 2'b00, 0));
        vt.push_back(mk(0, 2, 0, 8,  2'b01, 2'b00, 0));
        vt.push_back(mk(0, 3, 0, 7,  2'b01, 2'b01, 1));
        foreach (vt[i]) begin
            if (vt[i].ng)
                do_new_game();
            do_move(vt[i].col, r, l);
            chk($sformatf("vec%0d reject", i),     r,          vt[i].rej);
            chk($sformatf("vec%0d latency", i),    l,          vt[i].lat);
            chk($sformatf("vec%0d cur_player", i), cur_player, vt[i].cur);
            chk($sformatf("vec%0d winner", i),     winner,     vt[i].win);
            chk($sformatf("vec%0d game_over", i),  game_over,  vt[i].over);
        end

        // Game is over: further requests are ignored.
        move_valid = 1'b1;
        move_col   = 3'd4;
        watch_quiet(6, saw);
        move_valid = 1'b0;
        chk("over no response", saw, 1'b0);
        chk("over ready low", move_ready, 1'b0);
        chk("over board held", board, m_pack());
        chk("over winner held", winner, 2'b01);

        // Full board with no four-in-a-row ends in a draw.
        do_new_game();
        q = {};
        foreach (q[i]) q.delete(i);
        for (int p = 0; p < 3; p++) begin
            int a;
            int b;
            a = (p == 2) ? 4 : p;
            b = a + 2;
            for (int i = 0; i < 12; i++)
                q.push_back(((i % 4) == 0 || (i % 4) == 3) ? a : b);
        end
        for (int i = 0; i < 6; i++)
            q.push_back(5);
        foreach (q[i])
            do_move(q[i], r, l);
        chk("draw winner", winner, 2'b11);
        chk("draw game_over", game_over, 1'b1);
        chk("draw cur_player", cur_player, 2'b10);

        // new_game while the move is in CHECK.
        do_new_game();
        do_move(2, r, l);
        move_valid = 1'b1;
        move_col   = 3'd2;
        step();
        move_valid = 1'b0;
        repeat (3) step();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        m_reset();
        chk("ng-in-check board", board, 84'd0);
        chk("ng-in-check cur_player", cur_player, 2'b01);
        chk("ng-in-check ready", move_ready, 1'b1);
        watch_quiet(12, saw);
        chk("ng-in-check no pulse", saw, 1'b0);

        // rst while the move is in SCAN.
        do_move(5, r, l);
        do_move(5, r, l);
        move_valid = 1'b1;
        move_col   = 3'd5;
        step();
        move_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_reset();
        check_state("rst-in-scan");
        chk("rst-in-scan pulses", {move_done, move_reject}, 2'b00);
        watch_quiet(10, saw);
        chk("rst-in-scan no pulse", saw, 1'b0);
        do_move(5, r, l);
        chk("post-rst board[5][5]", board[5][5], 2'b01);
        chk("post-rst latency", l, 7);

        // new_game coinciding with a request in IDLE drops the request.
        do_move(1, r, l);
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_col   = 3'd1;
        step();
        new_game   = 1'b0;
        move_valid = 1'b0;
        m_reset();
        chk("ng+move ready", move_ready, 1'b1);
        watch_quiet(10, saw);
        chk("ng+move no pulse", saw, 1'b0);
        check_state("ng+move");

        // Random games against the model.
        for (int g = 0; g < 8; g++) begin
            do_new_game();
            moves = 0;
            while (!m_over && moves < 70) begin
                col = $urandom_range(0, 9);
                if (col > 7)
                    col = 3;
                repeat ($urandom_range(0, 2)) step();
                do_move(col, r, l);
                moves++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
